fifo_rd_stream: RTL and testbench

Read-side consumer stage in the rclk domain, downstream of the asynchronous FIFO. It pops words from the FIFO read port (rdata/rempty/rinc) and presents them on a valid/ready stream through a registered 2-entry skid buffer. It also provides a synchronous flush that discards buffered data and drains the FIFO, and a handshake counter for the verification scoreboard.

---
 rtl/fifo_rd_stream.sv | 124 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words into a 2-entry
// skid buffer and presents them on a valid/ready stream, with flush/drain.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             flush_busy,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [DSIZE-1:0] w_head_nxt;
    logic [DSIZE-1:0] w_tail_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_run;
    logic             w_push;
    logic             w_pop;

    assign w_run      = (r_state == S_RUN);
    assign out_valid  = w_run && (r_occ != 2'd0);
    assign out_data   = (r_occ != 2'd0) ? r_head : '0;
    assign flush_busy = (r_state == S_FLUSH);
    assign xfer_count = r_cnt;
    assign w_pop      = out_valid && out_ready;
    assign w_push     = w_run && fifo_rinc;

    // In FLUSH every available word is popped and dropped on the floor.
    always_comb begin
        fifo_rinc = 1'b0;
        if (!rrst && !fifo_rempty) begin
            fifo_rinc = w_run ? (r_occ != 2'd2) : 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_occ_nxt   = r_occ;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        unique case (r_state)
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                    w_occ_nxt   = 2'd0;
                end else begin
                    unique case ({w_push, w_pop})
                        2'b10: begin
                            if (r_occ == 2'd0) begin
                                w_head_nxt = fifo_rdata;
                            end else begin
                                w_tail_nxt = fifo_rdata;
                            end
                            w_occ_nxt = r_occ + 2'd1;
                        end
                        2'b01: begin
                            w_head_nxt = r_tail;
                            w_occ_nxt  = r_occ - 2'd1;
                        end
                        // Simultaneous push/pop only happens at occ=1.
                        2'b11: begin
                            w_head_nxt = fifo_rdata;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                if (fifo_rempty) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_occ_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= S_RUN;
            r_occ   <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    a_occ_range: assert property (@(posedge rclk) disable iff (rrst)
        r_occ <= 2'd2);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: FIFO read-port model, directed
// stimulus, and a negedge monitor checking every handshake in order.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic          fifo_rinc;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic          flush_busy;
    logic [CW-1:0] xfer_count;

    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    int nvec = 0;
    int nerr = 0;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DSIZE(DW),
        .CNT_W(CW)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_busy (flush_busy),
        .xfer_count (xfer_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base,
                              input bit keep);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(base + i);
            if (keep) exp_q.push_back(wr_data);
            cyc();
        end
        wr_en = 1'b0;
    endtask

    // FIFO read port: rdata/rempty follow the head, updated after each edge.
    initial begin : fifo_model
        fifo_rdata  = '0;
        fifo_rempty = 1'b1;
        forever begin
            @(posedge rclk);
            if (fifo_rinc && fq.size() > 0) void'(fq.pop_front());
            if (wr_en) fq.push_back(wr_data);
            fifo_rempty <= (fq.size() == 0);
            fifo_rdata  <= (fq.size() > 0) ? fq[0] : '0;
        end
    end

    initial begin : monitor
        logic [DW-1:0] pd;
        bit            ps;
        pd = '0;
        ps = 1'b0;
        forever begin
            @(negedge rclk);
            if (ps) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
            end
            ps = out_valid && !out_ready && !rrst && !flush;
            pd = out_data;
            if (fifo_rinc) chk("no_underflow", fifo_rempty, 0);
            if (flush_busy) chk("flush_novalid", out_valid, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL sb_extra: got 0x%0h expected none", out_data);
                end else begin
                    chk("sb_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int nrinc;
        int nhs;
        int run;
        int maxrun;
        int pops;
        rrst      = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;

        repeat (3) begin
            cyc();
            chk("rst_rinc", fifo_rinc, 0);
        end
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", xfer_count, 0);
        chk("rst_busy", flush_busy, 0);
        rrst = 1'b0;
        cyc();

        // Basic: three words, one-cycle latency from rempty falling
        out_ready = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'h11;
        exp_q.push_back(8'h11);
        cyc();
        chk("lat_rempty", fifo_rempty, 0);
        chk("lat_valid0", out_valid, 0);
        wr_data = 8'h22;
        exp_q.push_back(8'h22);
        cyc();
        chk("lat_valid1", out_valid, 1);
        chk("lat_data", out_data, 8'h11);
        wr_data = 8'h33;
        exp_q.push_back(8'h33);
        cyc();
        wr_en = 1'b0;
        repeat (4) cyc();
        chk("basic_cnt", xfer_count, 3);

        // Backpressure: buffer fills to two, FIFO pops stop
        out_ready = 1'b0;
        push_words(5, 8'h41, 1'b1);
        repeat (5) cyc();
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'h41);
        chk("bp_rinc", fifo_rinc, 0);
        chk("bp_fifo_left", fifo_rempty, 0);
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("bp_cnt", xfer_count, 8);
        chk("bp_drained", fifo_rempty, 1);

        // Streaming: 16 words at full rate
        nrinc  = 0;
        nhs    = 0;
        run    = 0;
        maxrun = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 16) begin
                wr_en   = 1'b1;
                wr_data = DW'(8'h80 + i);
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            cyc();
            if (fifo_rinc) nrinc++;
            if (out_valid && out_ready) begin
                nhs++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        chk("st_rinc", nrinc, 16);
        chk("st_hs", nhs, 16);
        chk("st_run", maxrun, 16);
        chk("st_cnt", xfer_count, 8);

        // Flush: two buffered plus three in the FIFO are discarded
        out_ready = 1'b0;
        push_words(5, 8'hF1, 1'b0);
        repeat (3) cyc();
        chk("fl_pre_valid", out_valid, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_busy", flush_busy, 1);
        chk("fl_valid", out_valid, 0);
        chk("fl_data", out_data, 0);
        pops = 0;
        for (int i = 0; i < 20 && flush_busy; i++) begin
            if (fifo_rinc) pops++;
            cyc();
        end
        chk("fl_done", flush_busy, 0);
        chk("fl_pops", pops, 3);
        chk("fl_cnt", xfer_count, 8);
        out_ready = 1'b1;
        push_words(1, 8'hA5, 1'b1);
        repeat (4) cyc();
        chk("fl_after_cnt", xfer_count, 9);

        // Reset with occ=2: buffered words lost, FIFO contents kept
        out_ready = 1'b0;
        push_words(2, 8'hC1, 1'b0);
        push_words(2, 8'hC3, 1'b1);
        chk("mr_valid", out_valid, 1);
        chk("mr_data", out_data, 8'hC1);
        rrst = 1'b1;
        cyc();
        chk("mr_valid0", out_valid, 0);
        chk("mr_cnt0", xfer_count, 0);
        chk("mr_rinc0", fifo_rinc, 0);
        cyc();
        chk("mr_rinc1", fifo_rinc, 0);
        chk("mr_fifo_kept", fifo_rempty, 0);
        rrst      = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();
        chk("mr_cnt", xfer_count, 2);

        // Counter wrap: 17 handshakes since reset on a 4-bit counter
        push_words(15, 8'h60, 1'b1);
        repeat (4) cyc();
        chk("wrap_cnt", xfer_count, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
